dmem_arbiter: RTL and testbench

Arbitrates the single-port synchronous data memory of the Riscv151 core between the CPU load/store port and the UART debug/bootloader port. The CPU has fixed priority, with a starvation guard that forces periodic debug slots. A lock mode gives the debug port exclusive ownership for bulk program loads. The arbiter sits between the datapath's memory stage and the dmem instance, and routes 1-cycle-latency read data back to whichever requester issued the read.

---
 rtl/riscv151_mem_pkg.sv | 15 +
 rtl/dmem_arbiter.sv | 116 +++++++++++
 tb/tb_dmem_arbiter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/riscv151_mem_pkg.sv
// Shared definitions for the Riscv151 data-memory path: requester IDs,
// arbiter state encoding and byte-enable width.
package riscv151_mem_pkg;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

    localparam int BE_WIDTH = 4;

    typedef enum logic {
        SHARED = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port dmem between the CPU and the UART debug port:
// CPU-first with a starvation guard, plus a debug lock for bulk loads.
module dmem_arbiter
    import riscv151_mem_pkg::*;
#(
    parameter int ADDR_WIDTH   = 14,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_valid,
    output logic                  cpu_ready,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [BE_WIDTH-1:0]   cpu_we,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_rvalid,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  dbg_valid,
    output logic                  dbg_ready,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [BE_WIDTH-1:0]   dbg_we,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    output logic                  dbg_rvalid,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
    input  logic                  dbg_lock,
    output logic                  mem_en,
    output logic [BE_WIDTH-1:0]   mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    arb_state_t state;
    logic [3:0] starve_cnt;
    logic       pending;
    logic       pend_id;
    logic       cpu_grant;
    logic       dbg_grant;

    // While locked the CPU is shut out entirely; otherwise debug only wins
    // when the CPU is idle or has exhausted its run of consecutive grants.
    always_comb begin
        cpu_grant = 1'b0;
        dbg_grant = 1'b0;
        if (state == LOCKED) begin
            dbg_grant = dbg_valid;
        end else begin
            dbg_grant = dbg_valid && (!cpu_valid || starve_cnt == LIMIT);
            cpu_grant = cpu_valid && !dbg_grant;
        end
    end

    assign cpu_ready = cpu_grant;
    assign dbg_ready = dbg_grant;

    always_comb begin
        mem_en   = 1'b0;
        mem_we   = '0;
        mem_addr = cpu_addr;
        mem_din  = cpu_wdata;
        if (dbg_grant) begin
            mem_en   = 1'b1;
            mem_we   = dbg_we;
            mem_addr = dbg_addr;
            mem_din  = dbg_wdata;
        end else if (cpu_grant) begin
            mem_en   = 1'b1;
            mem_we   = cpu_we;
        end
    end

    // The route register remembers who issued the read so the returning
    // mem_dout is qualified on the right port one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= SHARED;
            starve_cnt <= '0;
            pending    <= 1'b0;
            pend_id    <= REQ_CPU;
        end else begin
            pending <= (cpu_grant && cpu_we == '0) || (dbg_grant && dbg_we == '0);
            pend_id <= dbg_grant ? REQ_DBG : REQ_CPU;
            case (state)
                SHARED: begin
                    if (dbg_grant && dbg_lock) begin
                        state <= LOCKED;
                    end
                    if (dbg_grant || !dbg_valid) begin
                        starve_cnt <= '0;
                    end else if (cpu_grant && starve_cnt != LIMIT) begin
                        starve_cnt <= starve_cnt + 4'd1;
                    end
                end
                LOCKED: begin
                    starve_cnt <= '0;
                    if (!dbg_lock) begin
                        state <= SHARED;
                    end
                end
                default: begin
                    state      <= SHARED;
                    starve_cnt <= '0;
                end
            endcase
        end
    end

    assign cpu_rvalid = pending && (pend_id == REQ_CPU);
    assign dbg_rvalid = pending && (pend_id == REQ_DBG);
    assign cpu_rdata  = mem_dout;
    assign dbg_rdata  = mem_dout;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed requests push expected read
// data into per-port queues, a negedge monitor pops them as rvalids arrive.
module tb_dmem_arbiter;

    localparam logic [3:0] RD = 4'h0;
    localparam logic [3:0] WR = 4'hF;

    logic        clk;
    logic        rst;
    logic        cpu_valid, cpu_ready, cpu_rvalid;
    logic [13:0] cpu_addr;
    logic [3:0]  cpu_we;
    logic [31:0] cpu_wdata, cpu_rdata;
    logic        dbg_valid, dbg_ready, dbg_rvalid, dbg_lock;
    logic [13:0] dbg_addr;
    logic [3:0]  dbg_we;
    logic [31:0] dbg_wdata, dbg_rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [13:0] mem_addr;
    logic [31:0] mem_din, mem_dout;

    logic [31:0] mem  [0:255];
    logic [31:0] gold [0:255];
    logic [31:0] cpu_q[$];
    logic [31:0] dbg_q[$];
    int checks = 0;
    int failures = 0;

    dmem_arbiter #(.ADDR_WIDTH(14), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_addr(cpu_addr),
        .cpu_we(cpu_we), .cpu_wdata(cpu_wdata), .cpu_rvalid(cpu_rvalid),
        .cpu_rdata(cpu_rdata),
        .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_addr(dbg_addr),
        .dbg_we(dbg_we), .dbg_wdata(dbg_wdata), .dbg_rvalid(dbg_rvalid),
        .dbg_rdata(dbg_rdata), .dbg_lock(dbg_lock),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 1-cycle-latency synchronous dmem
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we != 4'h0) begin
                for (int b = 0; b < 4; b++)
                    if (mem_we[b]) mem[mem_addr[7:0]][8*b +: 8] <= mem_din[8*b +: 8];
            end else begin
                mem_dout <= mem[mem_addr[7:0]];
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (cpu_rvalid) begin
            if (cpu_q.size() == 0) check_output("cpu_rvalid_unexpected", 32'd1, 32'd0);
            else check_output("cpu_rdata", cpu_rdata, cpu_q.pop_front());
        end
        if (dbg_rvalid) begin
            if (dbg_q.size() == 0) check_output("dbg_rvalid_unexpected", 32'd1, 32'd0);
            else check_output("dbg_rdata", dbg_rdata, dbg_q.pop_front());
        end
    end

    // Drives one request cycle, checks grants and the memory port, and
    // records the expected read response of the winner.
    task automatic apply_stimulus(input string name,
                                  input logic cv, input logic [13:0] ca, input logic [3:0] cwe,
                                  input logic [31:0] cwd,
                                  input logic dv, input logic [13:0] da, input logic [3:0] dwe,
                                  input logic [31:0] dwd, input logic dl,
                                  input logic exp_cr, input logic exp_dr, input logic track);
        @(posedge clk);
        #1;
        cpu_valid = cv; cpu_addr = ca; cpu_we = cwe; cpu_wdata = cwd;
        dbg_valid = dv; dbg_addr = da; dbg_we = dwe; dbg_wdata = dwd; dbg_lock = dl;
        @(negedge clk);
        check_output({name, "/cpu_ready"}, {31'd0, cpu_ready}, {31'd0, exp_cr});
        check_output({name, "/dbg_ready"}, {31'd0, dbg_ready}, {31'd0, exp_dr});
        check_output({name, "/mem_en"}, {31'd0, mem_en}, {31'd0, exp_cr | exp_dr});
        if (exp_dr) begin
            check_output({name, "/mem_addr"}, {18'd0, mem_addr}, {18'd0, da});
            check_output({name, "/mem_we"}, {28'd0, mem_we}, {28'd0, dwe});
            if (dwe != 4'h0) check_output({name, "/mem_din"}, mem_din, dwd);
            if (track) begin
                if (dwe == 4'h0) dbg_q.push_back(gold[da[7:0]]);
                else gold[da[7:0]] = dwd;
            end
        end else if (exp_cr) begin
            check_output({name, "/mem_addr"}, {18'd0, mem_addr}, {18'd0, ca});
            check_output({name, "/mem_we"}, {28'd0, mem_we}, {28'd0, cwe});
            if (track) begin
                if (cwe == 4'h0) cpu_q.push_back(gold[ca[7:0]]);
                else gold[ca[7:0]] = cwd;
            end
        end else begin
            check_output({name, "/mem_we_idle"}, {28'd0, mem_we}, 32'd0);
        end
    endtask

    task automatic idle_cycle();
        apply_stimulus("idle", 1'b0, 14'd0, RD, 32'd0, 1'b0, 14'd0, RD, 32'd0, 1'b0,
                       1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]  = 32'h1000_0000 + i;
            gold[i] = 32'h1000_0000 + i;
        end
        mem_dout = 32'd0;
        rst = 1'b1;
        cpu_valid = 1'b0; cpu_addr = '0; cpu_we = '0; cpu_wdata = '0;
        dbg_valid = 1'b0; dbg_addr = '0; dbg_we = '0; dbg_wdata = '0; dbg_lock = 1'b0;

        @(negedge clk);
        check_output("reset/mem_en", {31'd0, mem_en}, 32'd0);
        check_output("reset/mem_we", {28'd0, mem_we}, 32'd0);
        check_output("reset/cpu_ready", {31'd0, cpu_ready}, 32'd0);
        check_output("reset/dbg_ready", {31'd0, dbg_ready}, 32'd0);
        check_output("reset/cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
        check_output("reset/dbg_rvalid", {31'd0, dbg_rvalid}, 32'd0);
        rst = 1'b0;

        // Lone CPU read of 0x10
        apply_stimulus("cpu_rd", 1'b1, 14'h10, RD, 32'd0, 1'b0, 14'd0, RD, 32'd0, 1'b0,
                       1'b1, 1'b0, 1'b1);
        idle_cycle();

        // Both requesting: four CPU grants then one forced debug slot
        for (int j = 0; j < 10; j++)
            apply_stimulus("starve", 1'b1, 14'h20, RD, 32'd0, 1'b1, 14'h30, RD, 32'd0, 1'b0,
                           (j % 5) != 4, (j % 5) == 4, 1'b1);
        idle_cycle();

        // Lock raised while CPU wins has no effect; lock taken once CPU idles
        apply_stimulus("lock_pre", 1'b1, 14'h40, RD, 32'd0, 1'b1, 14'd0, WR, 32'hA0, 1'b1,
                       1'b1, 1'b0, 1'b1);
        apply_stimulus("lock_take", 1'b0, 14'h40, RD, 32'd0, 1'b1, 14'd0, WR, 32'hA0, 1'b1,
                       1'b0, 1'b1, 1'b1);
        for (int i = 1; i < 8; i++)
            apply_stimulus("locked_wr", 1'b1, 14'h40, RD, 32'd0, 1'b1, 14'(i), WR, 32'hA0 + i,
                           1'b1, 1'b0, 1'b1, 1'b1);
        apply_stimulus("unlock_edge", 1'b1, 14'h40, RD, 32'd0, 1'b0, 14'd0, RD, 32'd0, 1'b0,
                       1'b0, 1'b0, 1'b1);
        apply_stimulus("unlocked_cpu", 1'b1, 14'h40, RD, 32'd0, 1'b0, 14'd0, RD, 32'd0, 1'b0,
                       1'b1, 1'b0, 1'b1);

        // Back-to-back CPU@3, DBG@5 (via starvation), CPU@7 over loaded data
        for (int i = 0; i < 4; i++)
            apply_stimulus("ilv_cpu", 1'b1, 14'(i), RD, 32'd0, 1'b1, 14'd5, RD, 32'd0, 1'b0,
                           1'b1, 1'b0, 1'b1);
        apply_stimulus("ilv_dbg", 1'b1, 14'd7, RD, 32'd0, 1'b1, 14'd5, RD, 32'd0, 1'b0,
                       1'b0, 1'b1, 1'b1);
        apply_stimulus("ilv_cpu7", 1'b1, 14'd7, RD, 32'd0, 1'b0, 14'd0, RD, 32'd0, 1'b0,
                       1'b1, 1'b0, 1'b1);
        idle_cycle();
        idle_cycle();

        // Reset right after a CPU read is accepted: its response must vanish
        apply_stimulus("rst_rd", 1'b1, 14'h10, RD, 32'd0, 1'b0, 14'd0, RD, 32'd0, 1'b0,
                       1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cpu_valid = 1'b0;
        @(negedge clk);
        check_output("rst/cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
        check_output("rst/mem_en", {31'd0, mem_en}, 32'd0);
        @(negedge clk);
        check_output("rst/cpu_rvalid_hold", {31'd0, cpu_rvalid}, 32'd0);
        rst = 1'b0;

        // Counter restarted from zero in SHARED after reset
        for (int j = 0; j < 5; j++)
            apply_stimulus("post_rst", 1'b1, 14'h11, RD, 32'd0, 1'b1, 14'h12, RD, 32'd0, 1'b0,
                           j != 4, j == 4, 1'b1);
        idle_cycle();
        idle_cycle();

        check_output("cpu_q_drained", cpu_q.size(), 32'd0);
        check_output("dbg_q_drained", dbg_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
